// File: rtl/eth_src_arbiter.sv
// eth_src_arbiter: round-robin sequencer that frames fixed-size bursts from NUM_CH source FIFOs
// into one byte stream (A5, {ch,seq}, payload). Define ARB_CHKSUM_EN to append an XOR checksum byte.
module eth_src_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int BURST_LEN = 64,
  parameter int LVL_W     = 12,
  parameter int GAP_CYC   = 2
) (
  input  logic                    data_clk,
  input  logic                    rst_n,
  input  logic                    transfer_flag,
  input  logic [NUM_CH*LVL_W-1:0] src_level,
  input  logic [NUM_CH*8-1:0]     src_data,
  output logic [NUM_CH-1:0]       src_rd,
  output logic                    out_en,
  output logic [7:0]              out_data,
  output logic                    busy,
  output logic [1:0]              grant_ch
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [7:0] SYNC = 8'hA5;

`ifdef ARB_CHKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_BURST, S_CHK, S_GAP} state_t;
  logic [7:0] r_acc;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_BURST, S_GAP} state_t;
`endif

  state_t            r_state, w_state_next;
  logic [CH_W-1:0]   r_g, r_rr_ptr, w_pick;
  logic              w_any_elig;
  logic [NUM_CH-1:0] w_elig;
  logic [5:0]        r_seq [NUM_CH];
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_gap_cnt;
  logic              r_out_en, r_busy;
  logic [7:0]        r_out_data;
  logic [1:0]        r_grant_ch;
  logic              w_last, w_frame_end, w_rd_active;
  logic [7:0]        w_src_byte, w_hdr1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_elig
      assign w_elig[gi] = (src_level[gi*LVL_W +: LVL_W] >= LVL_W'(BURST_LEN));
    end
  endgenerate

  // Scan downward so the candidate closest to rr_ptr is the last one written and wins.
  always_comb begin
    logic [CH_W:0] sum;
    w_pick     = '0;
    w_any_elig = 1'b0;
    sum        = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      sum = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      if (w_elig[sum[CH_W-1:0]]) begin
        w_pick     = sum[CH_W-1:0];
        w_any_elig = 1'b1;
      end
    end
  end

  assign w_src_byte  = src_data[{r_g, 3'b000} +: 8];
  assign w_hdr1      = {2'(r_g), r_seq[r_g]};
  assign w_last      = (r_cnt == CNT_W'(BURST_LEN - 1));
  // First read issues in HDR1, so BURST stops reading one cycle before its last capture.
  assign w_rd_active = (r_state == S_HDR1) || ((r_state == S_BURST) && !w_last);

`ifdef ARB_CHKSUM_EN
  assign w_frame_end = (r_state == S_CHK);
`else
  assign w_frame_end = (r_state == S_BURST) && w_last;
`endif

  always_comb begin
    src_rd = '0;
    if (w_rd_active) src_rd[r_g] = 1'b1;
  end

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!transfer_flag) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_any_elig) w_state_next = S_HDR0;
        S_HDR0:  w_state_next = S_HDR1;
        S_HDR1:  w_state_next = S_BURST;
        S_BURST: begin
`ifdef ARB_CHKSUM_EN
          if (w_last) w_state_next = S_CHK;
`endif
        end
`ifdef ARB_CHKSUM_EN
        S_CHK:   w_state_next = S_GAP;
`endif
        S_GAP:   if (r_gap_cnt == 4'(GAP_CYC - 1)) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
      if (w_frame_end) w_state_next = (GAP_CYC == 0) ? S_IDLE : S_GAP;
    end
  end

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_en   <= 1'b0;
      r_out_data <= '0;
      r_busy     <= 1'b0;
      r_grant_ch <= '0;
      r_g        <= '0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_gap_cnt  <= '0;
      for (int i = 0; i < NUM_CH; i++) r_seq[i] <= '0;
    end else begin
      r_busy   <= (w_state_next != S_IDLE);
      r_out_en <= 1'b0;
      if (!transfer_flag) begin
        r_rr_ptr <= '0;
        for (int i = 0; i < NUM_CH; i++) r_seq[i] <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_any_elig) begin
              r_g        <= w_pick;
              r_grant_ch <= 2'(w_pick);
            end
          end
          S_HDR0: begin
            r_out_en   <= 1'b1;
            r_out_data <= SYNC;
            r_cnt      <= '0;
            r_gap_cnt  <= '0;
          end
          S_HDR1: begin
            r_out_en   <= 1'b1;
            r_out_data <= w_hdr1;
          end
          S_BURST: begin
            r_out_en   <= 1'b1;
            r_out_data <= w_src_byte;
            r_cnt      <= r_cnt + 1'b1;
          end
`ifdef ARB_CHKSUM_EN
          S_CHK: begin
            r_out_en   <= 1'b1;
            r_out_data <= r_acc;
          end
`endif
          S_GAP:   r_gap_cnt <= r_gap_cnt + 1'b1;
          default: ;
        endcase
        if (w_frame_end) begin
          r_seq[r_g] <= r_seq[r_g] + 1'b1;
          r_rr_ptr   <= (r_g == CH_W'(NUM_CH - 1)) ? '0 : r_g + 1'b1;
        end
      end
    end
  end

`ifdef ARB_CHKSUM_EN
  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      case (r_state)
        S_HDR0:  r_acc <= SYNC;
        S_HDR1:  r_acc <= r_acc ^ w_hdr1;
        S_BURST: r_acc <= r_acc ^ w_src_byte;
        default: ;
      endcase
    end
  end
`endif

  assign out_en   = r_out_en;
  assign out_data = r_out_data;
  assign busy     = r_busy;
  assign grant_ch = r_grant_ch;
endmodule

// File: tb/tb_eth_src_arbiter.sv
// tb_eth_src_arbiter: directed and randomized checks of eth_src_arbiter against a frame-level model.
// Follows ARB_CHKSUM_EN when the bench is compiled with it.
module tb_eth_src_arbiter;
  localparam int NUM_CH    = 2;
  localparam int BURST_LEN = 64;
  localparam int LVL_W     = 12;
  localparam int GAP_CYC   = 2;
  localparam int MEM_D     = 8192;
`ifdef ARB_CHKSUM_EN
  localparam int FRAME_LEN = BURST_LEN + 3;
`else
  localparam int FRAME_LEN = BURST_LEN + 2;
`endif

  logic                    data_clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    transfer_flag = 1'b0;
  logic [NUM_CH*LVL_W-1:0] src_level = '0;
  logic [NUM_CH*8-1:0]     src_data = '0;
  logic [NUM_CH-1:0]       src_rd;
  logic                    out_en;
  logic [7:0]              out_data;
  logic                    busy;
  logic [1:0]              grant_ch;

  always #5 data_clk = ~data_clk;

  eth_src_arbiter #(.NUM_CH(NUM_CH), .BURST_LEN(BURST_LEN), .LVL_W(LVL_W), .GAP_CYC(GAP_CYC)) dut (
    .data_clk(data_clk), .rst_n(rst_n), .transfer_flag(transfer_flag),
    .src_level(src_level), .src_data(src_data), .src_rd(src_rd),
    .out_en(out_en), .out_data(out_data), .busy(busy), .grant_ch(grant_ch)
  );

  int tests = 0, fails = 0;
  byte unsigned mem [NUM_CH][MEM_D];
  int drv_ptr [NUM_CH];
  int lvl [NUM_CH];
  byte unsigned cur_q[$], frm_q[$], last_frm[$];
  int flen_q[$], fgap_q[$];
  int idle_run, bad_onehot, bad_elig, bad_run;
  int rd_run [NUM_CH];
  int m_rr;
  int m_seq [NUM_CH];
  int m_ptr [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Source FIFO emulation: data appears one cycle after the read strobe.
  initial begin
    logic [NUM_CH-1:0] rd_s;
    forever begin
      @(negedge data_clk);
      rd_s = src_rd;
      @(posedge data_clk);
      #1;
      for (int i = 0; i < NUM_CH; i++)
        if (rd_s[i]) begin
          src_data[i*8 +: 8] = mem[i][drv_ptr[i] % MEM_D];
          drv_ptr[i]++;
        end
    end
  end

  // Output capture: frames are runs of contiguous out_en cycles.
  initial begin
    forever begin
      @(negedge data_clk);
      if (out_en) begin
        if (cur_q.size() == 0) fgap_q.push_back(idle_run);
        cur_q.push_back(out_data);
        idle_run = 0;
      end else begin
        if (cur_q.size() > 0) begin
          flen_q.push_back(cur_q.size());
          foreach (cur_q[j]) frm_q.push_back(cur_q[j]);
          cur_q.delete();
        end
        idle_run++;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (src_rd[i]) begin
          rd_run[i]++;
          if (lvl[i] < BURST_LEN) bad_elig++;
        end else begin
          if (rd_run[i] > 0 && transfer_flag && rd_run[i] != BURST_LEN) bad_run++;
          rd_run[i] = 0;
        end
      end
      if ($countones(src_rd) > 1) bad_onehot++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_levels(input int l0, input int l1);
    lvl[0] = l0;
    lvl[1] = l1;
    for (int i = 0; i < NUM_CH; i++) src_level[i*LVL_W +: LVL_W] = LVL_W'(lvl[i]);
  endtask

  task automatic start_scn(input int l0, input int l1, input bit rnd_data);
    transfer_flag = 1'b0;
    repeat (3) @(negedge data_clk);
    cur_q.delete(); frm_q.delete(); flen_q.delete(); fgap_q.delete();
    set_levels(l0, l1);
    for (int i = 0; i < NUM_CH; i++) begin
      drv_ptr[i] = 0;
      m_ptr[i]   = 0;
      m_seq[i]   = 0;
      for (int j = 0; j < MEM_D; j++) mem[i][j] = rnd_data ? 8'($urandom) : 8'(j + 1);
    end
    m_rr = 0;
    transfer_flag = 1'b1;
  endtask

  // Model: grant = first channel at or after the rr pointer with level >= BURST_LEN;
  // frame = A5, {ch,seq}, next BURST_LEN bytes of that channel's stream [, XOR of all].
  task automatic expect_frames(input int n, input bit chk_gap);
    byte unsigned b[$];
    for (int f = 0; f < n; f++) begin
      int budget, ch, len, gap, err, c;
      logic [7:0] x, e, hdr;
      budget = 0; ch = -1; err = 0;
      b.delete();
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (ch < 0 && lvl[c] >= BURST_LEN) ch = c;
      end
      while (flen_q.size() == 0 && budget < 1000) begin
        @(negedge data_clk);
        budget++;
      end
      chk("frame arrives in time", 32'(flen_q.size() > 0), 1);
      if (flen_q.size() == 0 || ch < 0) return;
      len = flen_q.pop_front();
      gap = fgap_q.pop_front();
      for (int j = 0; j < len; j++) b.push_back(frm_q.pop_front());
      last_frm = b;
      hdr = 8'((ch << 6) | m_seq[ch]);
      chk("frame length", len, FRAME_LEN);
      chk("sync byte", b[0], 8'hA5);
      chk("header byte1", (len > 1) ? 32'(b[1]) : 32'hFFFF_FFFF, hdr);
      x = 8'hA5 ^ hdr;
      for (int j = 0; j < BURST_LEN; j++) begin
        e = mem[ch][m_ptr[ch] % MEM_D];
        m_ptr[ch]++;
        x = x ^ e;
        if (j + 2 >= len) err++;
        else if (b[j+2] !== e) err++;
      end
      chk("payload byte mismatches", err, 0);
`ifdef ARB_CHKSUM_EN
      chk("checksum byte", (len > BURST_LEN + 2) ? 32'(b[BURST_LEN+2]) : 32'hFFFF_FFFF, x);
`endif
      if (chk_gap && f > 0) chk("idle cycles between frames", gap, GAP_CYC + 1);
      m_seq[ch] = (m_seq[ch] + 1) % 64;
      m_rr = (ch + 1) % NUM_CH;
    end
  endtask

  initial begin
    int budget, act, l0, l1;
    // Reset with the flag low and plenty of data: nothing may move.
    set_levels(1000, 1000);
    repeat (3) @(negedge data_clk);
    chk("reset src_rd", src_rd, 0);
    chk("reset out_en", out_en, 0);
    chk("reset out_data", out_data, 0);
    chk("reset busy", busy, 0);
    chk("reset grant_ch", grant_ch, 0);
    rst_n = 1'b1;
    act = 0;
    repeat (100) begin
      @(negedge data_clk);
      if (out_en || src_rd != 0 || busy) act++;
    end
    chk("activity with flag low", act, 0);

    // Single eligible channel: one full frame from ch0.
    start_scn(100, 0, 1'b1);
    expect_frames(1, 1'b0);
    $display("[TB] single-channel frame checked, tests=%0d", tests);

    // Both eligible: grants alternate, sequence per channel, fixed gap.
    start_scn(100, 200, 1'b1);
    expect_frames(6, 1'b1);
    $display("[TB] alternating grants checked, tests=%0d", tests);

    // Sequence number wraps 63 -> 0 after 64 frames on the same channel.
    start_scn(64, 0, 1'b1);
    expect_frames(65, 1'b1);
    chk("wrap frame byte1", (last_frm.size() > 1) ? 32'(last_frm[1]) : 32'hFFFF_FFFF, 8'h00);
    $display("[TB] sequence wrap checked, tests=%0d", tests);

    // Abort mid-burst, then restart from a clean sequence.
    start_scn(100, 0, 1'b1);
    expect_frames(2, 1'b1);
    budget = 0;
    while (cur_q.size() < 12 && budget < 500) begin
      @(negedge data_clk);
      budget++;
    end
    chk("reached payload byte 10", cur_q.size(), 12);
    chk("busy mid-frame", busy, 1);
    transfer_flag = 1'b0;
    @(negedge data_clk);
    chk("abort out_en", out_en, 0);
    chk("abort src_rd", src_rd, 0);
    chk("abort busy", busy, 0);
    @(negedge data_clk);
    chk("truncated frame length", (flen_q.size() > 0) ? flen_q[0] : 0, 12);
    start_scn(100, 0, 1'b1);
    expect_frames(1, 1'b0);
    $display("[TB] abort and restart checked, tests=%0d", tests);

`ifdef ARB_CHKSUM_EN
    // Payload 01..40 on ch1: XOR(01..40) = 40 cancels header byte 40, leaving A5.
    start_scn(0, 100, 1'b0);
    expect_frames(1, 1'b0);
    chk("grant_ch for ch1", grant_ch, 1);
    chk("fixed-payload checksum", (last_frm.size() == FRAME_LEN) ? 32'(last_frm[FRAME_LEN-1]) : 32'hFFFF_FFFF, 8'hA5);
    $display("[TB] checksum frame checked, tests=%0d", tests);
`endif

    // Random levels and data.
    for (int r = 0; r < 5; r++) begin
      l0 = $urandom_range(0, 130);
      l1 = $urandom_range(0, 130);
      start_scn(l0, l1, 1'b1);
      if (l0 >= BURST_LEN || l1 >= BURST_LEN) begin
        expect_frames(4, 1'b1);
      end else begin
        act = 0;
        repeat (150) begin
          @(negedge data_clk);
          if (out_en || src_rd != 0) act++;
        end
        chk("no activity without eligible channel", act, 0);
      end
      $display("[TB] random levels %0d/%0d checked, tests=%0d", l0, l1, tests);
    end

    transfer_flag = 1'b0;
    repeat (3) @(negedge data_clk);
    chk("src_rd one-hot violations", bad_onehot, 0);
    chk("reads to ineligible channel", bad_elig, 0);
    chk("read runs not BURST_LEN long", bad_run, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
